// File: rtl/gf180mcu_fd_sc_mcu9t5v0__par3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__par3_pkg: shared types/constants for the frame checker
// Rev 1.0
// ---------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0__par3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RES  = 2'd2
  } state_t;

  localparam logic PAR_EVEN      = 1'b0;
  localparam logic PAR_ODD       = 1'b1;
  localparam int   FRAME_LEN_MAX = 256;

  // Bit to fold into the accumulated parity for the selected check mode.
  function automatic logic par_flip(input logic mode);
    logic f;
    f = 1'b0;
    case (mode)
      PAR_EVEN: f = 1'b0;
      PAR_ODD:  f = 1'b1;
      default:  f = 1'b0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xnor3_1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__xnor3_1: behavioural 3-input XNOR cell
// Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__xnor3_1 (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic ZN
);

  assign ZN = ~(A1 ^ A2 ^ A3);

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk: streaming frame-parity checker
// Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk
  import gf180mcu_fd_sc_mcu9t5v0__par3_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire           VDD,
  inout  wire           VSS,
`endif
  input  logic          CLK,
  input  logic          RST,
  input  logic          A1,
  input  logic          A2,
  input  logic          A3,
  input  logic          VALID,
  input  logic          SOF,
  input  logic          PEXP,
  input  logic          MODE,
  output logic          READY,
  input  logic          ACK,
  output logic          DONE,
  output logic          ERR,
  output logic          FERR,
  output logic [CW-1:0] CNT
);

  localparam logic [CW:0] LEN_EXT = (CW + 1)'(FRAME_LEN);

  generate
    if (FRAME_LEN < 1 || FRAME_LEN > FRAME_LEN_MAX) begin : g_len_check
      $error("FRAME_LEN out of range");
    end
  endgenerate

  state_t        state, state_n;
  logic          p, p_n;
  logic          pexp_l, pexp_n;
  logic          ferr_n;
  logic [CW-1:0] cnt_n;
  logic [CW:0]   cnt_inc;
  logic          xn;
  logic          g;
  logic          accept;

  gf180mcu_fd_sc_mcu9t5v0__xnor3_1 u_xnor3 (
`ifdef USE_POWER_PINS
    .VDD (VDD),
    .VSS (VSS),
`endif
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .ZN  (xn)
  );

  assign g       = ~xn;
  // READY is held low while reset is applied, not just decoded from state.
  assign READY   = !RST && (state != RES);
  assign accept  = VALID && READY;
  assign cnt_inc = {1'b0, CNT} + (CW + 1)'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    p_n     = p;
    cnt_n   = CNT;
    pexp_n  = pexp_l;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (SOF) begin
            p_n   = g;
            cnt_n = CW'(1);
            if (FRAME_LEN == 1) begin
              pexp_n  = PEXP;
              state_n = RES;
            end else begin
              state_n = ACC;
            end
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (SOF) begin
            ferr_n = 1'b1;
            p_n    = g;
            cnt_n  = CW'(1);
          end else begin
            p_n   = p ^ g;
            cnt_n = cnt_inc[CW-1:0];
            if (cnt_inc == LEN_EXT) begin
              pexp_n  = PEXP;
              state_n = RES;
            end
          end
        end
      end
      RES: begin
        if (ACK) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ERR is re-evaluated every RES cycle so MODE is sampled continuously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p      <= 1'b0;
      pexp_l <= 1'b0;
      CNT    <= '0;
      FERR   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      p      <= p_n;
      pexp_l <= pexp_n;
      CNT    <= cnt_n;
      FERR   <= ferr_n;
      DONE   <= (state_n == RES);
      ERR    <= (state_n == RES) && ((p_n ^ par_flip(MODE)) != pexp_n);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk: directed + random bench vs frame model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, a2, a3, valid, sof, pexp, mode, ack;
  logic       ready4, done4, err4, ferr4;
  logic [2:0] cnt4;
  logic       ready1, done1, err1, ferr1;
  logic [0:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the current frame is kept as the list of accepted group bits.
  bit m_q[$];
  bit m_res;
  bit m_pexp;
  bit m_ferr;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk #(.FRAME_LEN(4)) dut4 (
    .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .A3(a3), .VALID(valid), .SOF(sof),
    .PEXP(pexp), .MODE(mode), .READY(ready4), .ACK(ack), .DONE(done4),
    .ERR(err4), .FERR(ferr4), .CNT(cnt4)
  );

  gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk #(.FRAME_LEN(1)) dut1 (
    .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .A3(a3), .VALID(valid), .SOF(sof),
    .PEXP(pexp), .MODE(mode), .READY(ready1), .ACK(ack), .DONE(done1),
    .ERR(err1), .FERR(ferr1), .CNT(cnt1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit q_parity();
    bit r = 1'b0;
    foreach (m_q[i]) r ^= m_q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_res  = 1'b0;
    m_pexp = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_edge();
    bit g = a1 ^ a2 ^ a3;
    m_ferr = 1'b0;
    if (m_res) begin
      if (ack) begin
        m_res = 1'b0;
        m_q.delete();
      end
    end else if (valid) begin
      if (sof) begin
        m_ferr = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(g);
      end else if (m_q.size() == 0) begin
        m_ferr = 1'b1;
      end else begin
        m_q.push_back(g);
      end
      if (m_q.size() == 4) begin
        m_res  = 1'b1;
        m_pexp = pexp;
      end
    end
  endtask

  task automatic check_all();
    check("done",  done4,  m_res);
    check("err",   err4,   m_res && ((q_parity() ^ mode) != m_pexp));
    check("ferr",  ferr4,  m_ferr);
    check("cnt",   cnt4,   m_q.size());
    check("ready", ready4, !m_res && !rst);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit s, input bit [2:0] a, input bit pe);
    valid = v;
    sof   = s;
    {a1, a2, a3} = a;
    pexp  = pe;
  endtask

  task automatic send_frame4(input bit pe);
    drive(1, 1, 3'b001, 0); step();
    drive(1, 0, 3'b011, 0); step();
    drive(1, 0, 3'b111, 0); step();
    drive(1, 0, 3'b000, pe); step();
  endtask

  initial begin
    rst = 1'b1;
    ack = 1'b0;
    mode = 1'b0;
    drive(0, 0, 3'b000, 0);
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;
    check("ready_after_rst", ready4, 1);

    // Pass case, then hold DONE with ACK low while VALID keeps arriving.
    send_frame4(0);
    check("pass_done", done4, 1);
    check("pass_err", err4, 0);
    check("pass_ready", ready4, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, i[0], 3'b101, 1);
      step();
      check("hold_cnt", cnt4, 4);
    end
    ack = 1'b1;
    step();
    check("ack_cnt", cnt4, 0);
    check("ack_done", done4, 0);

    // Mismatch with ACK already high: DONE for one cycle only.
    mode = 1'b0;
    send_frame4(1);
    check("mis_err", err4, 1);
    drive(0, 0, 3'b000, 0);
    step();
    check("mis_done_1cyc", done4, 0);

    mode = 1'b1;
    send_frame4(1);
    check("odd_err", err4, 0);
    drive(0, 0, 3'b000, 0);
    step();
    ack = 1'b0;
    mode = 1'b0;

    // SOF on the third group restarts the frame.
    drive(1, 1, 3'b100, 0); step();
    drive(1, 0, 3'b110, 0); step();
    drive(1, 1, 3'b010, 0); step();
    check("sof_mid_ferr", ferr4, 1);
    check("sof_mid_cnt", cnt4, 1);
    drive(1, 0, 3'b111, 0); step();
    check("ferr_pulse_end", ferr4, 0);
    drive(1, 0, 3'b000, 0); step();
    drive(1, 0, 3'b001, 1); step();
    check("restart_done", done4, 1);
    ack = 1'b1;
    drive(0, 0, 3'b000, 0);
    step();
    ack = 1'b0;

    // Non-SOF group in IDLE.
    drive(1, 0, 3'b011, 0); step();
    check("idle_ferr", ferr4, 1);
    check("idle_cnt", cnt4, 0);

    // Asynchronous reset mid-frame.
    drive(1, 1, 3'b001, 0); step();
    drive(1, 0, 3'b001, 0); step();
    check("pre_rst_cnt", cnt4, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", cnt4, 0);
    check("arst_ready", ready4, 0);
    check("arst_done", done4, 0);
    check("arst_ferr", ferr4, 0);
    model_reset();
    step();
    rst = 1'b0;
    #1;
    check("rel_ready", ready4, 1);
    send_frame4(0);
    check("post_rst_err", err4, 0);
    check("post_rst_done", done4, 1);
    ack = 1'b1;
    drive(0, 0, 3'b000, 0);
    step();
    ack = 1'b0;

    // FRAME_LEN=1 instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 1, 3'b110, 0);
    step();
    check("len1_done", done1, 1);
    check("len1_err", err1, 0);
    check("len1_ready", ready1, 0);
    check("len1_cnt", cnt1, 1);
    ack = 1'b1;
    drive(0, 0, 3'b000, 0);
    step();
    check("len1_idle", done1, 0);
    drive(1, 1, 3'b100, 0);
    step();
    check("len1_err_mis", err1, 1);
    step();
    ack = 1'b0;
    drive(0, 0, 3'b000, 0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit idle = !m_res && (m_q.size() == 0);
      if (idle && ($urandom_range(0, 7) == 0)) mode = $urandom_range(0, 1);
      valid = ($urandom_range(0, 3) != 0);
      sof   = idle ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 11) == 0);
      a1    = $urandom_range(0, 1);
      a2    = $urandom_range(0, 1);
      a3    = $urandom_range(0, 1);
      pexp  = $urandom_range(0, 1);
      ack   = ($urandom_range(0, 4) < 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk.md
# gf180mcu_fd_sc_mcu9t5v0__par3_frame_chk

Streaming frame-parity checker that sits directly downstream of the 9-track XNOR3 cell. Each accepted cycle carries a 3-bit group on A1/A2/A3. The XNOR3 reduces that group to one bit, and this block accumulates the bits over a fixed-length frame. At frame end it compares the accumulated parity against an expected bit and reports pass/fail through a DONE/ACK handshake.

## Interface
Parameters:
- FRAME_LEN, default 8: groups per frame; legal range 1..256.
- CW, default $clog2(FRAME_LEN+1): group-counter width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- A1, A2, A3  in  1 each  data bits of the current group.
- VALID  in  1  group present on A1..A3, SOF and PEXP.
- SOF  in  1  group is the first of a frame.
- PEXP  in  1  expected frame parity; sampled only with the last group.
- MODE  in  1  0 = even check; 1 = odd check.
- READY  out  1  block accepts a group this cycle.
- ACK  in  1  consumer has taken the result.
- DONE  out  1  result valid; held until ACK.
- ERR  out  1  parity mismatch; valid while DONE=1.
- FERR  out  1  one-cycle framing-error pulse.
- CNT  out  CW  groups accepted in the current frame.
- VDD, VSS  inout  power pins; present only under USE_POWER_PINS.

## Operation
- Accept: a group is taken when VALID && READY at the CLK rising edge.
- Group bit: g = ~xn, where xn = XNOR3(A1,A2,A3). Equivalently, g = A1^A2^A3.
- FSM states:
  - IDLE: READY=1.
    - Accepted group with SOF=1: P<=g, CNT<=1. Goes to ACC, or to RES if FRAME_LEN=1.
    - Accepted group with SOF=0: the group is discarded and FERR pulses. State stays IDLE.
  - ACC: READY=1.
    - Accepted group with SOF=0: P<=P^g, CNT<=CNT+1.
    - When CNT+1 == FRAME_LEN: PEXP is latched and the state goes to RES.
    - Accepted group with SOF=1: the current frame is aborted and FERR pulses. The frame restarts with P<=g, CNT<=1, and the state stays ACC.
  - RES: READY=0, DONE=1, ERR = (P^MODE) != PEXP_latched.
    - ACK=1: the state goes to IDLE next cycle and CNT<=0.
- Inputs ignored while READY=0: VALID, SOF and A1..A3.
- MODE: sampled continuously in RES. It must be held stable for the whole frame.
- Counter: CNT never exceeds FRAME_LEN. No wrap-around is reachable.

## Timing
- Reset values, forced while RST=1: state IDLE, P=0, CNT=0, DONE=0, ERR=0, FERR=0, READY=0.
- READY rises combinationally from IDLE once RST is released.
- Latency: DONE asserts on the first edge after the last group is accepted, i.e. one cycle.
- Throughput: back-to-back groups are accepted with no bubbles inside a frame.
- Frame boundary: one mandatory RES cycle sits between frames.
  - Minimum frame period is FRAME_LEN+1 cycles when ACK is already high.
- ACK outside RES: ignored.
- ACK in the same cycle DONE rises: legal; DONE lasts exactly one cycle.
- FERR: registered, high for exactly the cycle after the offending accept.
- RST asserted mid-frame or in RES: all state is dropped immediately, with no DONE or FERR.
- Outputs: ERR, DONE, FERR and CNT are registered. READY is decoded from state.

## Structure
- Shared package gf180mcu_fd_sc_mcu9t5v0__par3_pkg holds:
  - state enum {IDLE, ACC, RES};
  - MODE encodings PAR_EVEN=0 and PAR_ODD=1;
  - FRAME_LEN_MAX=256.
- Sub-module: one instance of gf180mcu_fd_sc_mcu9t5v0__xnor3_1 produces xn.
  - Power pins are passed through under USE_POWER_PINS.
- Everything else stays in this module: FSM, accumulator, counter, PEXP latch.

## Test plan
- Pass case, FRAME_LEN=4, MODE=0, PEXP=0.
  - Stimulus: groups 001(SOF), 011, 111, 000, with VALID held high.
  - Required: DONE=1 and ERR=0 on the cycle after the 4th accept; READY=0 that cycle.
- Mismatch: same frame with PEXP=1 -> ERR=1. With MODE=1 and PEXP=1 -> ERR=0.
- DONE hold: ACK held low for 5 cycles.
  - Required: DONE stays 1, READY stays 0, and VALID groups are not counted (CNT stays 4).
  - ACK=1 -> IDLE next cycle with CNT=0.
- Framing errors:
  - SOF=1 on the 3rd group of a frame -> FERR pulse; CNT=1; frame completes 3 groups later.
  - Non-SOF group in IDLE -> FERR pulse; CNT stays 0.
- Reset: RST raised asynchronously with CNT=2.
  - Required: outputs go to their reset values before the next edge.
  - After release, READY=1 and the next SOF frame checks correctly.
- FRAME_LEN=1: a SOF group of 110 with PEXP=0 -> DONE on the next cycle, ERR=0.
